// File: rtl/stall_mem_responder_pkg.sv
// Shared definitions for the stalling memory responder: FSM state
// encoding and the default geometry/latency of the storage array.
package stall_mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_DEPTH_W = 8;
   localparam int DEFAULT_LATENCY = 4;
   localparam int DATA_W          = 16;

endpackage

// File: rtl/stall_mem_responder_mem_array_1rw.sv
// Word storage for the responder: one synchronous write port and one
// asynchronous read port. Contents are deliberately never reset.
module mem_array_1rw
   import stall_mem_responder_pkg::*;
#(
   parameter int DEPTH_W = DEFAULT_DEPTH_W
) (
   input  logic               clk,
   input  logic               we,
   input  logic [DEPTH_W-1:0] waddr,
   input  logic [DATA_W-1:0]  wdata,
   input  logic [DEPTH_W-1:0] raddr,
   output logic [DATA_W-1:0]  rdata
);

   logic [DATA_W-1:0] mem_q [2**DEPTH_W];

   // Write port: commits one word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/stall_mem_responder.sv
// Responder side of the stalling memory handshake. A buffer miss holds
// Stall for LATENCY cycles and then pulses Done; a repeat read of the
// most recently read word completes immediately with CacheHit.
module stall_mem_responder
   import stall_mem_responder_pkg::*;
#(
   parameter int DEPTH_W = DEFAULT_DEPTH_W,
   parameter int LATENCY = DEFAULT_LATENCY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] Addr,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              Rd,
   input  logic              Wr,
   output logic [DATA_W-1:0] DataOut,
   output logic              Done,
   output logic              Stall,
   output logic              CacheHit,
   output logic              err
);

   // The counter holds the number of BUSY cycles still to go, so the
   // accepting IDLE cycle plus the BUSY cycles add up to LATENCY stalls.
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                op_wr_q, op_wr_d;
   logic [DEPTH_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                buf_valid_q, buf_valid_d;
   logic [DEPTH_W-1:0]  buf_idx_q, buf_idx_d;
   logic [DATA_W-1:0]   buf_data_q, buf_data_d;

   logic                mem_we;
   logic [DEPTH_W-1:0]  mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DEPTH_W-1:0]  mem_raddr;
   logic [DATA_W-1:0]   mem_rdata;

   logic [DEPTH_W-1:0]  req_idx;
   logic                legal_req;
   logic                illegal_req;
   logic                unused_addr_bits;

   // Upper address bits alias onto the array and are intentionally dropped.
   assign req_idx          = Addr[DEPTH_W:1];
   assign unused_addr_bits = ^Addr[DATA_W-1:DEPTH_W+1];
   assign legal_req        = (Rd ^ Wr) & ~Addr[0];
   assign illegal_req      = (Rd & Wr) | ((Rd | Wr) & Addr[0]);

   mem_array_1rw #(
      .DEPTH_W (DEPTH_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // Next-state, array port control and handshake outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_wr_d     = op_wr_q;
      idx_d       = idx_q;
      data_d      = data_q;
      buf_valid_d = buf_valid_q;
      buf_idx_d   = buf_idx_q;
      buf_data_d  = buf_data_q;
      mem_we      = 1'b0;
      mem_waddr   = idx_q;
      mem_wdata   = data_q;
      mem_raddr   = idx_q;
      DataOut     = '0;
      Done        = 1'b0;
      Stall       = 1'b0;
      CacheHit    = 1'b0;
      err         = 1'b0;

      case (state_q)
         IDLE: begin
            mem_raddr = req_idx;
            if (illegal_req) begin
               err = 1'b1;
            end else if (legal_req) begin
               if (Rd && buf_valid_q && (buf_idx_q == req_idx)) begin
                  Done     = 1'b1;
                  CacheHit = 1'b1;
                  DataOut  = buf_data_q;
               end else if (LATENCY == 0) begin
                  Done = 1'b1;
                  if (Rd) begin
                     DataOut     = mem_rdata;
                     buf_valid_d = 1'b1;
                     buf_idx_d   = req_idx;
                     buf_data_d  = mem_rdata;
                  end else begin
                     mem_we    = 1'b1;
                     mem_waddr = req_idx;
                     mem_wdata = DataIn;
                  end
               end else begin
                  Stall   = 1'b1;
                  op_wr_d = Wr;
                  idx_d   = req_idx;
                  data_d  = DataIn;
                  cnt_d   = CNT_INIT;
                  if (LATENCY > 1) begin
                     state_d = BUSY;
                  end else begin
                     state_d = DONE;
                     if (Wr) begin
                        mem_we    = 1'b1;
                        mem_waddr = req_idx;
                        mem_wdata = DataIn;
                     end
                  end
               end
            end
         end
         BUSY: begin
            Stall = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = DONE;
               mem_we  = op_wr_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            Done    = 1'b1;
            state_d = IDLE;
            if (!op_wr_q) begin
               DataOut     = mem_rdata;
               buf_valid_d = 1'b1;
               buf_idx_d   = idx_q;
               buf_data_d  = mem_rdata;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (mem_we && buf_valid_q && (mem_waddr == buf_idx_q)) begin
         buf_data_d = mem_wdata;
      end

      if (!rst) begin
         DataOut  = '0;
         Done     = 1'b0;
         Stall    = 1'b0;
         CacheHit = 1'b0;
         err      = 1'b0;
         mem_we   = 1'b0;
      end
   end

   // State, latched request and last-read buffer registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         op_wr_q     <= 1'b0;
         idx_q       <= '0;
         data_q      <= '0;
         buf_valid_q <= 1'b0;
         buf_idx_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         buf_valid_q <= buf_valid_d;
         buf_idx_q   <= buf_idx_d;
         buf_data_q  <= buf_data_d;
      end
   end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Bench for stall_mem_responder: one instance with LATENCY=4 and one with
// LATENCY=0, each checked against a word-array plus last-read-address model.
module tb_stall_mem_responder;

   logic        clk = 1'b0;
   logic        rstN     [2];
   logic [15:0] addrIn   [2];
   logic [15:0] dataIn   [2];
   logic        rdIn     [2];
   logic        wrIn     [2];
   logic [15:0] dataOut  [2];
   logic        doneOut  [2];
   logic        stallOut [2];
   logic        hitOut   [2];
   logic        errOut   [2];

   logic [15:0] memModel [2][256];
   bit          bufValid [2];
   logic [7:0]  bufIdx   [2];
   int          latency  [2] = '{4, 0};

   int errors = 0;
   int checks = 0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   stall_mem_responder #(.DEPTH_W(8), .LATENCY(4)) dut4 (
      .clk(clk), .rst(rstN[0]), .Addr(addrIn[0]), .DataIn(dataIn[0]),
      .Rd(rdIn[0]), .Wr(wrIn[0]), .DataOut(dataOut[0]), .Done(doneOut[0]),
      .Stall(stallOut[0]), .CacheHit(hitOut[0]), .err(errOut[0])
   );

   stall_mem_responder #(.DEPTH_W(8), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rstN[1]), .Addr(addrIn[1]), .DataIn(dataIn[1]),
      .Rd(rdIn[1]), .Wr(wrIn[1]), .DataOut(dataOut[1]), .Done(doneOut[1]),
      .Stall(stallOut[1]), .CacheHit(hitOut[1]), .err(errOut[1])
   );

   // One comparison: counts it, and counts and reports it when it differs.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Full request/response: holds the request while stalled (optionally
   // scrambling Addr/DataIn after acceptance) and checks the completion.
   task automatic applyStimulus(input int d, input bit isWr, input logic [15:0] a,
                                input logic [15:0] din, input bit scramble, input string tag);
      logic [7:0]  idx;
      bit          hit;
      int          expLat;
      logic [15:0] expData;
      int          nStall;
      idx     = a[8:1];
      hit     = !isWr && bufValid[d] && (bufIdx[d] == idx);
      expLat  = hit ? 0 : latency[d];
      expData = isWr ? 16'h0000 : memModel[d][idx];
      @(negedge clk);
      rdIn[d]   = !isWr;
      wrIn[d]   = isWr;
      addrIn[d] = a;
      dataIn[d] = din;
      #1;
      nStall = 0;
      while (stallOut[d] === 1'b1 && nStall < 20) begin
         checkOutput({tag, "/busy_quiet"}, {15'd0, doneOut[d], dataOut[d]}, 32'd0);
         nStall++;
         @(negedge clk);
         if (scramble) begin
            addrIn[d] = 16'($urandom);
            dataIn[d] = 16'($urandom);
         end
         #1;
      end
      checkOutput({tag, "/stall_cycles"}, nStall, expLat);
      checkOutput({tag, "/done"}, {31'd0, doneOut[d]}, 32'd1);
      checkOutput({tag, "/data"}, {16'd0, dataOut[d]}, {16'd0, expData});
      checkOutput({tag, "/hit_err"}, {30'd0, hitOut[d], errOut[d]}, {30'd0, hit, 1'b0});
      if (isWr) begin
         memModel[d][idx] = din;
      end else begin
         bufValid[d] = 1'b1;
         bufIdx[d]   = idx;
      end
      @(posedge clk);
      #1;
      rdIn[d] = 1'b0;
      wrIn[d] = 1'b0;
   endtask

   // Illegal request for one cycle: only err may respond.
   task automatic applyIllegal(input int d, input bit rd, input bit wr,
                               input logic [15:0] a, input string tag);
      @(negedge clk);
      rdIn[d]   = rd;
      wrIn[d]   = wr;
      addrIn[d] = a;
      dataIn[d] = 16'hDEAD;
      #1;
      checkOutput({tag, "/err"}, {12'd0, errOut[d], stallOut[d], doneOut[d], hitOut[d], dataOut[d]},
                  {12'd0, 4'b1000, 16'd0});
      @(posedge clk);
      #1;
      rdIn[d] = 1'b0;
      wrIn[d] = 1'b0;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rstN[d] = 1'b0; rdIn[d] = 1'b1; wrIn[d] = 1'b0;
         addrIn[d] = 16'h0000; dataIn[d] = 16'h0000; bufValid[d] = 1'b0; bufIdx[d] = 8'd0;
      end
      #2;
      checkOutput("reset4", {12'd0, errOut[0], stallOut[0], doneOut[0], hitOut[0], dataOut[0]}, 32'd0);
      checkOutput("reset0", {12'd0, errOut[1], stallOut[1], doneOut[1], hitOut[1], dataOut[1]}, 32'd0);
      rdIn[0] = 1'b0; rdIn[1] = 1'b0;
      @(negedge clk);
      rstN[0] = 1'b1; rstN[1] = 1'b1;
      #1;
      checkOutput("idle4", {12'd0, errOut[0], stallOut[0], doneOut[0], hitOut[0], dataOut[0]}, 32'd0);

      // Give every word a known value so the model never guesses.
      for (int i = 0; i < 256; i++) begin
         applyStimulus(0, 1'b1, 16'(i * 2), 16'($urandom), 1'b0, "init4");
         applyStimulus(1, 1'b1, 16'(i * 2), 16'($urandom), 1'b0, "init0");
      end

      $display("[TB] LATENCY=4 directed sequence");
      applyStimulus(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "wr_beef");
      applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_beef_miss");
      applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_beef_hit");
      applyStimulus(0, 1'b1, 16'h0010, 16'h1234, 1'b0, "wr_1234");
      applyStimulus(0, 1'b0, 16'h0010, 16'h0000, 1'b0, "rd_1234_hit");

      applyIllegal(0, 1'b1, 1'b0, 16'h0011, "misaligned");
      applyIllegal(0, 1'b1, 1'b1, 16'h0020, "rd_and_wr");
      applyStimulus(0, 1'b0, 16'h0020, 16'h0000, 1'b0, "rd_0020_prior");

      // Abort a write with reset in its second BUSY cycle.
      applyStimulus(0, 1'b0, 16'h0040, 16'h0000, 1'b0, "rd_0040_fill");
      @(negedge clk);
      wrIn[0] = 1'b1; addrIn[0] = 16'h0040; dataIn[0] = 16'hAAAA;
      #1;
      checkOutput("abort_accept", {31'd0, stallOut[0]}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("abort_busy2", {31'd0, stallOut[0]}, 32'd1);
      rstN[0] = 1'b0;
      #1;
      checkOutput("abort_outputs", {12'd0, errOut[0], stallOut[0], doneOut[0], hitOut[0], dataOut[0]}, 32'd0);
      @(negedge clk);
      wrIn[0] = 1'b0;
      rstN[0] = 1'b1;
      bufValid[0] = 1'b0;
      applyStimulus(0, 1'b0, 16'h0040, 16'h0000, 1'b0, "rd_0040_after_rst");

      applyStimulus(0, 1'b1, 16'h0004, 16'h0F0F, 1'b1, "wr_scrambled");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 1'b0, 16'(i * 2), 16'h0000, 1'b0, "rd_after_scramble");
      end

      $display("[TB] LATENCY=4 random sequence");
      for (int i = 0; i < 60; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 1)),
                       16'(($urandom_range(0, 7) * 2) | ($urandom_range(0, 1) << 9)),
                       16'($urandom), ($urandom_range(0, 3) == 0), "rand4");
      end

      $display("[TB] LATENCY=0 directed and random sequence");
      applyStimulus(1, 1'b1, 16'h0002, 16'h5555, 1'b0, "z_wr_5555");
      applyStimulus(1, 1'b0, 16'h0002, 16'h0000, 1'b0, "z_rd_5555");
      applyStimulus(1, 1'b0, 16'h0202, 16'h0000, 1'b0, "z_rd_alias");
      applyIllegal(1, 1'b0, 1'b1, 16'h0003, "z_misaligned");
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1, 1'($urandom_range(0, 1)),
                       16'(($urandom_range(0, 7) * 2) | ($urandom_range(0, 1) << 9)),
                       16'($urandom), 1'b0, "rand0");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
